// File: rtl/vedic_mul_seq.sv
// Sequential Vedic multiplier: one HALFxHALF unsigned partial product per
// cycle (ll, lh, hl, hh), sign fixed up at the end, valid/ready on both sides.
module vedic_mul_seq #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Z,
  output logic                 busy
);

  localparam int HALF = WIDTH / 2;
  localparam int ZW   = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       step;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg;
  logic [ZW-1:0]    acc;
  logic [ZW-1:0]    z_q;

  logic             a_sgn, b_sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             accept;

  logic [HALF-1:0]  op_a, op_b;
  logic [WIDTH-1:0] prod;
  logic [ZW-1:0]    pp_ext, pp_sh;

  // mode 11 falls through to the unsigned path
  assign a_sgn  = (mode == 2'b01) || (mode == 2'b10);
  assign b_sgn  = (mode == 2'b01);
  assign a_neg  = a_sgn & A[WIDTH-1];
  assign b_neg  = b_sgn & B[WIDTH-1];
  assign a_abs  = a_neg ? -A : A;
  assign b_abs  = b_neg ? -B : B;
  assign accept = in_valid & (state == IDLE) & ~flush;

  assign op_a   = step[1] ? a_mag[WIDTH-1:HALF] : a_mag[HALF-1:0];
  assign op_b   = step[0] ? b_mag[WIDTH-1:HALF] : b_mag[HALF-1:0];
  assign prod   = {{HALF{1'b0}}, op_a} * {{HALF{1'b0}}, op_b};
  assign pp_ext = {{WIDTH{1'b0}}, prod};

  always_comb begin
    pp_sh = pp_ext;
    unique case (step)
      2'd0:    pp_sh = pp_ext;
      2'd1:    pp_sh = pp_ext << HALF;
      2'd2:    pp_sh = pp_ext << HALF;
      2'd3:    pp_sh = pp_ext << WIDTH;
      default: pp_sh = pp_ext;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (step == 2'd3) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step  <= '0;
      a_mag <= '0;
      b_mag <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      z_q   <= '0;
    end else if (flush) begin
      step  <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      z_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_mag <= a_abs;
            b_mag <= b_abs;
            neg   <= a_neg ^ b_neg;
            acc   <= '0;
            step  <= '0;
          end
        end
        CALC: begin
          acc  <= acc + pp_sh;
          step <= step + 2'd1;
        end
        FIX:     z_q <= neg ? -acc : acc;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign Z         = z_q;

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Scoreboard bench for vedic_mul_seq: 64-, 16- and 8-bit instances run in
// lockstep off one stimulus stream, each checked against a wide reference.
module tb_vedic_mul_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [63:0]  a = '0;
  logic [63:0]  b = '0;
  logic [1:0]   mode = '0;

  logic         rdy64, rdy16, rdy8;
  logic         ov64, ov16, ov8;
  logic         bz64, bz16, bz8;
  logic [127:0] z64;
  logic [31:0]  z16;
  logic [15:0]  z8;

  typedef struct packed {
    logic [127:0] z64;
    logic [31:0]  z16;
    logic [15:0]  z8;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vedic_mul_seq #(.WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .A(a), .B(b), .mode(mode),
    .out_valid(ov64), .out_ready(out_ready),
    .Z(z64), .busy(bz64)
  );

  vedic_mul_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy16),
    .A(a[15:0]), .B(b[15:0]), .mode(mode),
    .out_valid(ov16), .out_ready(out_ready),
    .Z(z16), .busy(bz16)
  );

  vedic_mul_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy8),
    .A(a[7:0]), .B(b[7:0]), .mode(mode),
    .out_valid(ov8), .out_ready(out_ready),
    .Z(z8), .busy(bz8)
  );

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] x,
                                           input logic [63:0] y,
                                           input logic [1:0] m,
                                           input int w);
    logic signed [127:0] tx, ty;
    logic [127:0] ax, bx, p;
    int sh;
    sh = 128 - w;
    tx = {64'b0, x} << sh;
    ty = {64'b0, y} << sh;
    if (m == 2'b01 || m == 2'b10) ax = tx >>> sh;
    else                          ax = tx >> sh;
    if (m == 2'b01) bx = ty >>> sh;
    else            bx = ty >> sh;
    p = ax * bx;
    if (w < 64) p = p & ((128'd1 << (2 * w)) - 128'd1);
    return p;
  endfunction

  // called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [63:0] x, input logic [63:0] y,
                      input logic [1:0] m);
    exp_t e;
    int n;
    n = 0;
    while (!rdy64 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 128'(rdy64), 128'd1);
    a = x;
    b = y;
    mode = m;
    in_valid = 1'b1;
    @(posedge clk);
    e.z64 = ref_mul(x, y, m, 64);
    e.z16 = 32'(ref_mul(x, y, m, 16));
    e.z8  = 16'(ref_mul(x, y, m, 8));
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    mode = 2'($urandom_range(0, 3));
  endtask

  task automatic collect(output logic [127:0] exp64);
    exp_t e;
    int lat;
    lat = 0;
    exp64 = '0;
    while (!ov64 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", 128'(lat), 128'd5);
    check("ov16", 128'(ov16), 128'd1);
    check("ov8", 128'(ov8), 128'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 128'(sb.size()), 128'd1);
    end else begin
      e = sb.pop_front();
      exp64 = e.z64;
      check("z64", z64, e.z64);
      check("z16", 128'(z16), 128'(e.z16));
      check("z8", 128'(z8), 128'(e.z8));
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("ack_ov", 128'(ov64), 128'd0);
    check("ack_rdy", 128'(rdy64), 128'd1);
  endtask

  task automatic run(input logic [63:0] x, input logic [63:0] y,
                     input logic [1:0] m);
    logic [127:0] ez;
    send(x, y, m);
    collect(ez);
    ack();
  endtask

  logic [63:0] edges [7] = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'h8000_0000_0000_0000, 64'h8000,
                             64'h80, 64'h7FFF_FFFF_FFFF_FFFF};

  initial begin
    logic [127:0] ez;
    int seen;

    #1;
    check("rst_rdy", 128'(rdy64), 128'd1);
    check("rst_ov", 128'(ov64), 128'd0);
    check("rst_busy", 128'(bz64), 128'd0);
    check("rst_z", z64, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00);
    collect(ez);
    check("uu_max", z64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    ack();

    send(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 2'b01);
    collect(ez);
    check("ss_m3x7", z64, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);
    ack();

    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01);
    collect(ez);
    check("ss_minmin", z64, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    ack();

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10);
    collect(ez);
    check("su_m1xmax", z64, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);
    ack();

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
    collect(ez);
    check("m11_as_00", z64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    ack();

    // flush sampled at the step-2 edge
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2'b00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    void'(sb.pop_back());
    check("flush_busy", 128'(bz64), 128'd0);
    check("flush_rdy", 128'(rdy64), 128'd1);
    check("flush_z", z64, 128'd0);
    check("flush_z16", 128'(z16), 128'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | int'(ov64);
    end
    check("flush_no_ov", 128'(seen), 128'd0);

    // flush wins over the output handshake
    send(64'd5, 64'd6, 2'b00);
    collect(ez);
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    flush = 1'b0;
    check("flush_hs_z", z64, 128'd0);
    check("flush_hs_ov", 128'(ov64), 128'd0);
    check("flush_hs_rdy", 128'(rdy64), 128'd1);

    // flush in IDLE blocks acceptance
    a = 64'd3;
    b = 64'd3;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_busy", 128'(bz64), 128'd0);

    // asynchronous reset mid-calculation
    run(64'd9, 64'd9, 2'b00);
    send(64'd3, 64'd4, 2'b00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("arst_busy", 128'(bz64), 128'd0);
    check("arst_ov", 128'(ov64), 128'd0);
    check("arst_rdy", 128'(rdy64), 128'd1);
    check("arst_z", z64, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // backpressure, then back-to-back accept
    send(64'hDEAD_BEEF_0000_0001, 64'hFFFF_0000_1234_5678, 2'b01);
    collect(ez);
    a = 64'h0000_0000_0001_0003;
    b = 64'hFFFF_FFFF_FFFF_FF05;
    mode = 2'b10;
    in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_ov", 128'(ov64), 128'd1);
      check("bp_rdy", 128'(rdy64), 128'd0);
      check("bp_z", z64, ez);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_ov_fall", 128'(ov64), 128'd0);
    check("bp_rdy_rise", 128'(rdy64), 128'd1);
    @(posedge clk);
    begin
      exp_t e;
      e.z64 = ref_mul(a, b, mode, 64);
      e.z16 = 32'(ref_mul(a, b, mode, 16));
      e.z8  = 16'(ref_mul(a, b, mode, 8));
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_busy", 128'(bz64), 128'd1);
    collect(ez);
    ack();

    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < 7; j++)
          run(edges[i], edges[j], 2'(m));

    for (int k = 0; k < 1000; k++)
      run({$urandom, $urandom}, {$urandom, $urandom},
          2'($urandom_range(0, 3)));

    check("sb_drained", 128'(sb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
